mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle 16-bit multiply/divide unit holding the architectural HI/LO registers for the 16-bit MIPS datapath.
- Sits in the execute stage, directly upstream of the writeback result select.
- Its Result output is one data input of the 16-bit writeback mux. Busy drives the pipeline stall logic.

Parameters:
- WIDTH, 16, operand width. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  request a new operation; sampled only in IDLE.
- Op  in  1  0 = multiply, 1 = divide.
- Signed  in  1  signed-operation request; used only when SIGNED_MD_EN is defined.
- Ain  in  WIDTH  multiplicand / dividend.
- Bin  in  WIDTH  multiplier / divisor.
- ReadHi  in  1  Result select: 1 = HI, 0 = LO.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- DivByZero  out  1  flag for the completed operation.
- HI  out  WIDTH  high product half, or remainder.
- LO  out  WIDTH  low product half, or quotient.
- Result  out  WIDTH  combinational: ReadHi ? HI : LO.

Behaviour:
- Reset (Resetn low, asynchronous): state = IDLE; HI, LO, internal accumulators and iteration counter = 0; Busy = 0, Done = 0, DivByZero = 0.
- Reset mid-operation aborts the operation; HI and LO become 0 and no Done is generated.
- States:
  - IDLE: Busy = 0, Done = 0.
  - MUL: Busy = 1.
  - DIV: Busy = 1.
  - FIN: Done = 1, Busy = 0.
- IDLE transitions on a Start-sampled edge (edge 0):
  - Latch Ain, Bin, Op and Signed; clear the counter.
  - Op = 0 -> MUL.
  - Op = 1 with Bin != 0 -> DIV.
  - Op = 1 with Bin == 0 -> FIN at edge 1. At that edge HI = Ain, LO = all-ones, DivByZero = 1.
- MUL: shift-add, one multiplier bit per edge, on edges 1..WIDTH.
  - At edge WIDTH: {HI, LO} = the full 2*WIDTH-bit product; go to FIN; DivByZero = 0.
- DIV: restoring division, one quotient bit per edge, on edges 1..WIDTH.
  - At edge WIDTH: LO = quotient, HI = remainder; go to FIN; DivByZero = 0.
- FIN -> IDLE unconditionally on the next edge. Done is high for exactly one cycle.
- HI and LO change only at the edge entering FIN. They otherwise hold their last value.
- DivByZero holds its value until the next operation completes.
- Start is ignored in MUL, DIV and FIN; no queuing.
  - A Start held high through FIN is accepted on the first IDLE edge.
- Latched operands are used throughout, so Ain and Bin may change after edge 0.
- Arithmetic is unsigned, modulo 2^WIDTH per half. No carries are lost in the product.

Optional Feature:
- Macro: SIGNED_MD_EN.
- Defined, with Signed latched = 1:
  - Operands are converted to magnitudes, and the unsigned core runs unchanged.
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
  - Negation happens at the FIN-entry write; latency is unchanged.
  - -32768 / -1 gives LO = 0x8000, HI = 0x0000 (wrap, no flag).
  - Divide-by-zero behaviour is the same as unsigned: HI = Ain, LO = 0xFFFF.
- Not defined: the Signed port exists but is ignored, and all operations are unsigned.

Test Plan:
- Multiply, Op = 0, Ain = 0xFFFF, Bin = 0xFFFF, Start at edge 0:
  - Busy = 1 through edge 15.
  - Done pulses after edge 16 with HI = 0xFFFE, LO = 0x0001, DivByZero = 0.
  - ReadHi = 1 gives Result = 0xFFFE.
- Divide, Ain = 100, Bin = 7: Done after edge 16, LO = 14, HI = 2.
- Divide by zero, Ain = 0x1234, Bin = 0: Done after edge 1, HI = 0x1234, LO = 0xFFFF, DivByZero = 1.
- Start busy/back-to-back:
  - Assert Start with Ain = 3, Bin = 3 at edge 5 of a 5 * 6 multiply: ignored; result HI = 0, LO = 30.
  - Start held high through FIN: new operation accepted the edge after FIN.
- Reset abort: Resetn low at edge 8 of a divide gives immediate Busy = 0, HI = LO = 0, and no Done. A following 9 / 3 then gives LO = 3, HI = 0.
- SIGNED_MD_EN, Signed = 1:
  - -3 * 5 -> HI = 0xFFFF, LO = 0xFFF1.
  - -7 / 2 -> LO = 0xFFFD, HI = 0xFFFF.
  - Without the macro, 0xFFF9 / 2 -> LO = 0x7FFC, HI = 0x0001.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle WIDTH-bit multiply/divide unit holding the HI/LO registers.
// Optional signed operation is enabled by defining SIGNED_MD_EN.
module mult_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_ain,
  input  logic [WIDTH-1:0] i_bin,
  input  logic             i_read_hi,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b;
  logic [2*WIDTH-1:0] r_p;
  logic [CW-1:0]      r_cnt;
  logic               r_neg_p, r_neg_r;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_dbz;

  logic               w_sgn;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt, w_prod;
  logic [WIDTH:0]     w_div_shift, w_div_diff;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [WIDTH-1:0]   w_quo, w_rem, w_a_orig;
  logic               w_last, w_div_zero;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

`ifdef SIGNED_MD_EN
  assign w_sgn = i_signed;
`else
  logic w_unused_signed;
  assign w_unused_signed = i_signed;
  assign w_sgn           = 1'b0;
`endif

  // Shift-add step: r_p holds {partial high half, remaining multiplier bits}.
  assign w_mul_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
  assign w_mul_nxt = {w_mul_sum, r_p[WIDTH-1:1]};

  // Restoring step: r_p holds {partial remainder, dividend bits becoming quotient}.
  assign w_div_shift = r_p[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_nxt   = w_div_diff[WIDTH]
                     ? {w_div_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_p[WIDTH-2:0], 1'b1};

  assign w_prod     = f_neg2(w_mul_nxt, r_neg_p);
  assign w_quo      = f_neg(w_div_nxt[WIDTH-1:0], r_neg_p);
  assign w_rem      = f_neg(w_div_nxt[2*WIDTH-1:WIDTH], r_neg_r);
  assign w_a_orig   = f_neg(r_a, r_neg_r);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_div_zero = (r_b == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_neg_p <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_a     <= f_neg(i_ain, w_sgn & i_ain[WIDTH-1]);
            r_b     <= f_neg(i_bin, w_sgn & i_bin[WIDTH-1]);
            r_p     <= {{WIDTH{1'b0}}, (i_op ? f_neg(i_ain, w_sgn & i_ain[WIDTH-1])
                                             : f_neg(i_bin, w_sgn & i_bin[WIDTH-1]))};
            r_cnt   <= '0;
            r_neg_p <= w_sgn & (i_ain[WIDTH-1] ^ i_bin[WIDTH-1]);
            r_neg_r <= w_sgn & i_ain[WIDTH-1];
          end
        end
        S_MUL: begin
          r_p   <= w_mul_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_hi  <= w_prod[2*WIDTH-1:WIDTH];
            r_lo  <= w_prod[WIDTH-1:0];
            r_dbz <= 1'b0;
          end
        end
        S_DIV: begin
          if (w_div_zero) begin
            r_hi  <= w_a_orig;
            r_lo  <= '1;
            r_dbz <= 1'b1;
          end else begin
            r_p   <= w_div_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
              r_hi  <= w_rem;
              r_lo  <= w_quo;
              r_dbz <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = i_op ? S_DIV : S_MUL;
      S_MUL: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = S_FIN;
      end
      S_DIV: begin
        o_busy = 1'b1;
        if (w_div_zero || w_last) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_hi          = r_hi;
  assign o_lo          = r_lo;
  assign o_div_by_zero = r_dbz;
  assign o_result      = i_read_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit with a plain-arithmetic reference model.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, op, sgn, read_hi;
  logic [15:0] ain, bin;
  logic        busy, done, dbz;
  logic [15:0] hi, lo, result;
  int          total = 0;
  int          bad = 0;

  mult_div_unit #(.WIDTH(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_signed(sgn),
    .i_ain(ain), .i_bin(bin), .i_read_hi(read_hi),
    .o_busy(busy), .o_done(done), .o_div_by_zero(dbz),
    .o_hi(hi), .o_lo(lo), .o_result(result)
  );

  always #5 clk = ~clk;

  // Returns {dbz, hi, lo} from ordinary integer arithmetic.
  function automatic logic [32:0] model(input logic mop, input logic [15:0] a, input logic [15:0] b,
                                        input logic msg);
    logic [31:0] p;
    logic [15:0] q, r;
    int          sa, sb, iq, ir;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (mop == 1'b0) begin
      p = {16'h0, a} * {16'h0, b};
`ifdef SIGNED_MD_EN
      if (msg) p = 32'(sa * sb);
`endif
      return {1'b0, p};
    end
    if (b == 16'h0) return {1'b1, a, 16'hFFFF};
    q = a / b;
    r = a % b;
`ifdef SIGNED_MD_EN
    if (msg) begin
      iq = sa / sb;
      ir = sa % sb;
      q  = iq[15:0];
      r  = ir[15:0];
    end
`else
    iq = sa + sb + int'(msg);
    ir = iq;
`endif
    return {1'b0, r, q};
  endfunction

  // Launches one operation, scrambles inputs after edge 0, returns edge count to Done (-1 on timeout).
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int lat);
    @(negedge clk);
    op = o; ain = a; bin = b; sgn = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; ain = 16'($urandom); bin = 16'($urandom); op = 1'($urandom); sgn = 1'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 100) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; sgn = 1'b0; read_hi = 1'b0; ain = 16'hA5A5; bin = 16'h5A5A;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", dbz); end
    total++; if ({hi, lo} !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h want=0", {hi, lo}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || result !== 16'h0) begin bad++; $display("FAIL reset_idle busy=%b result=%h want 0/0", busy, result); end
  endtask

  task automatic test_mul_corner();
    @(negedge clk);
    op = 1'b0; ain = 16'hFFFF; bin = 16'hFFFF; sgn = 1'b0; start = 1'b1;
    for (int e = 0; e < 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; ain = 16'h0; bin = 16'h0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL mul_busy edge=%0d busy=%b done=%b want 1/0", e, busy, done); end
    end
    @(posedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mul_done done=%b busy=%b want 1/0", done, busy); end
    total++; if (hi !== 16'hFFFE || lo !== 16'h0001) begin bad++; $display("FAIL mul_ffff got=%h_%h want=fffe_0001", hi, lo); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL mul_dbz got=%b want=0", dbz); end
    read_hi = 1'b1; #1;
    total++; if (result !== 16'hFFFE) begin bad++; $display("FAIL mul_result_hi got=%h want=fffe", result); end
    read_hi = 1'b0; #1;
    total++; if (result !== 16'h0001) begin bad++; $display("FAIL mul_result_lo got=%h want=0001", result); end
    @(posedge clk);
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_divide();
    int lat;
    run_op(1'b1, 16'd100, 16'd7, 1'b0, lat);
    total++; if (lat !== 16) begin bad++; $display("FAIL div_latency got=%0d want=16", lat); end
    total++; if (lo !== 16'd14 || hi !== 16'd2) begin bad++; $display("FAIL div_100_7 got hi=%0d lo=%0d want hi=2 lo=14", hi, lo); end
    run_op(1'b1, 16'h1234, 16'h0000, 1'b0, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
    total++; if (hi !== 16'h1234 || lo !== 16'hFFFF || dbz !== 1'b1) begin
      bad++; $display("FAIL dbz_result got hi=%h lo=%h dbz=%b want 1234/ffff/1", hi, lo, dbz);
    end
    repeat (3) @(negedge clk);
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_hold got=%b want=1", dbz); end
  endtask

  task automatic test_start_ignored();
    logic [15:0] ph, pl;
    int          lat;
    ph = hi; pl = lo;
    @(negedge clk);
    op = 1'b0; ain = 16'd5; bin = 16'd6; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; ain = 16'd3; bin = 16'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (hi !== ph || lo !== pl) begin bad++; $display("FAIL hilo_hold got=%h_%h want=%h_%h", hi, lo, ph, pl); end
    lat = 8;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    total++; if (lat !== 16) begin bad++; $display("FAIL ignore_latency got=%0d want=16", lat); end
    total++; if (hi !== 16'd0 || lo !== 16'd30) begin bad++; $display("FAIL ignore_result got=%0d_%0d want=0_30", hi, lo); end
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    op = 1'b0; ain = 16'd2; bin = 16'd3; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ain = 16'd7; bin = 16'd4;
    repeat (16) @(posedge clk);
    @(negedge clk);
    total++; if (done !== 1'b1 || hi !== 16'd0 || lo !== 16'd6) begin
      bad++; $display("FAIL b2b_first done=%b got=%0d_%0d want 1 0_6", done, hi, lo);
    end
    @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%b done=%b want 0/0", busy, done); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b want=1", busy); end
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge clk); lat++; @(negedge clk); end
    total++; if (lat !== 16 || hi !== 16'd0 || lo !== 16'd28) begin
      bad++; $display("FAIL b2b_second lat=%0d got=%0d_%0d want 16 0_28", lat, hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    int lat;
    @(negedge clk);
    op = 1'b1; ain = 16'd500; bin = 16'd9; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || hi !== 16'h0 || lo !== 16'h0) begin
      bad++; $display("FAIL abort_state busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_done got=%0d pulses want=0", seen); end
    run_op(1'b1, 16'd9, 16'd3, 1'b0, lat);
    total++; if (lat !== 16 || lo !== 16'd3 || hi !== 16'd0) begin
      bad++; $display("FAIL abort_next lat=%0d got=%0d_%0d want 16 0_3", lat, hi, lo);
    end
  endtask

  task automatic test_signed();
    int lat;
`ifdef SIGNED_MD_EN
    run_op(1'b0, 16'hFFFD, 16'd5, 1'b1, lat);
    total++; if (hi !== 16'hFFFF || lo !== 16'hFFF1) begin bad++; $display("FAIL smul got=%h_%h want=ffff_fff1", hi, lo); end
    run_op(1'b1, 16'hFFF9, 16'd2, 1'b1, lat);
    total++; if (lo !== 16'hFFFD || hi !== 16'hFFFF) begin bad++; $display("FAIL sdiv got=%h_%h want=ffff_fffd", hi, lo); end
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b1, lat);
    total++; if (lo !== 16'h8000 || hi !== 16'h0000 || dbz !== 1'b0) begin
      bad++; $display("FAIL sdiv_wrap got=%h_%h dbz=%b want=0000_8000 0", hi, lo, dbz);
    end
    run_op(1'b1, 16'hFF00, 16'h0, 1'b1, lat);
    total++; if (hi !== 16'hFF00 || lo !== 16'hFFFF || dbz !== 1'b1) begin
      bad++; $display("FAIL sdbz got=%h_%h dbz=%b want=ff00_ffff 1", hi, lo, dbz);
    end
`else
    run_op(1'b1, 16'hFFF9, 16'd2, 1'b1, lat);
    total++; if (lo !== 16'h7FFC || hi !== 16'h0001) begin bad++; $display("FAIL udiv_signed_ignored got=%h_%h want=0001_7ffc", hi, lo); end
    run_op(1'b0, 16'hFFFD, 16'd5, 1'b1, lat);
    total++; if (hi !== 16'h0004 || lo !== 16'hFFF1) begin bad++; $display("FAIL umul_signed_ignored got=%h_%h want=0004_fff1", hi, lo); end
`endif
    total++; if (lat !== 16 && lat !== 1) begin bad++; $display("FAIL signed_latency got=%0d", lat); end
  endtask

  task automatic test_random();
    logic [32:0] exp;
    logic [15:0] a, b;
    logic        o, s;
    int          lat;
    for (int n = 0; n < 40; n++) begin
      o = 1'($urandom);
      s = 1'($urandom);
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      exp = model(o, a, b, s);
      run_op(o, a, b, s, lat);
      total++; if (lat !== ((o && b == 16'h0) ? 1 : 16)) begin
        bad++; $display("FAIL rnd_latency n=%0d op=%b a=%h b=%h got=%0d", n, o, a, b, lat);
      end
      total++; if ({dbz, hi, lo} !== exp) begin
        bad++; $display("FAIL rnd_result n=%0d op=%b s=%b a=%h b=%h got=%b_%h_%h want=%b_%h_%h",
                        n, o, s, a, b, dbz, hi, lo, exp[32], exp[31:16], exp[15:0]);
      end
      read_hi = 1'($urandom); #1;
      total++; if (result !== (read_hi ? exp[31:16] : exp[15:0])) begin
        bad++; $display("FAIL rnd_readsel n=%0d sel=%b got=%h", n, read_hi, result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_corner();
    test_divide();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_signed();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
